// File: rtl/imul_pipe.sv
// Pipelined integer multiply / byte-permute unit: partial products in stage 1, product summed and delayed to LAT.
// Optional byte-swap ops 6/7 are built only when IMUL_PIPE_BSWAP_EN is defined.
module imul_pipe #(
  parameter int WIDTH = 64,
  parameter int LAT   = 3,
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             en,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic [WIDTH-1:0] Res,
  output logic [5:0]       flg,
  output logic             valid_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int H = WIDTH / 2;
  localparam int P = 2 * WIDTH;

  // Handshake: no back-pressure. An op is taken when clkEn && en at a rising edge;
  // valid_out is a one-enabled-cycle strobe LAT enabled edges later, held while clkEn=0.

  // Issue decode: pick operand extension so one signed (W+1)x(W+1) multiply covers all ops.
  logic [WIDTH-1:0] a_x, b_x;
  logic             sa, sb;
  always_comb begin
    a_x = A;
    b_x = B;
    sa  = 1'b0;
    sb  = 1'b0;
    case (op)
      4'd0, 4'd2: begin sa = 1'b1; sb = 1'b1; end
      4'd3:       sa = 1'b1;
      4'd4: begin
        a_x = WIDTH'(A[31:0]);
        b_x = WIDTH'(B[31:0]);
      end
      4'd5: begin
        a_x = WIDTH'($signed(A[31:0]));
        b_x = WIDTH'($signed(B[31:0]));
        sa  = 1'b1;
        sb  = 1'b1;
      end
      default: ;
    endcase
  end

  logic [WIDTH:0] a_e, b_e;
  assign a_e = {sa & a_x[WIDTH-1], a_x};
  assign b_e = {sb & b_x[WIDTH-1], b_x};

  // Low halves are unsigned, high halves carry the sign of the extended operand.
  logic signed [WIDTH+1:0] ah_s, al_s, bh_s, bl_s;
  assign ah_s = {{(H+1){a_e[WIDTH]}}, a_e[WIDTH:H]};
  assign bh_s = {{(H+1){b_e[WIDTH]}}, b_e[WIDTH:H]};
  assign al_s = {{(H+2){1'b0}}, a_e[H-1:0]};
  assign bl_s = {{(H+2){1'b0}}, b_e[H-1:0]};

  logic signed [WIDTH+1:0] pp_hh_q, pp_hl_q, pp_lh_q, pp_ll_q;
  logic                    v_q   [1:LAT-1];
  logic [3:0]              op_q  [1:LAT-1];
  logic [TAG_W-1:0]        tag_q [1:LAT-1];
  logic [WIDTH-1:0]        a_q   [1:LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pp_hh_q <= '0;
      pp_hl_q <= '0;
      pp_lh_q <= '0;
      pp_ll_q <= '0;
      for (int k = 1; k < LAT; k++) begin
        v_q[k]   <= 1'b0;
        op_q[k]  <= '0;
        tag_q[k] <= '0;
        a_q[k]   <= '0;
      end
    end else begin
      if (clkEn) begin
        pp_hh_q  <= ah_s * bh_s;
        pp_hl_q  <= ah_s * bl_s;
        pp_lh_q  <= al_s * bh_s;
        pp_ll_q  <= al_s * bl_s;
        v_q[1]   <= en;
        op_q[1]  <= op;
        tag_q[1] <= tag_in;
        a_q[1]   <= A;
        for (int k = 2; k < LAT; k++) begin
          v_q[k]   <= v_q[k-1];
          op_q[k]  <= op_q[k-1];
          tag_q[k] <= tag_q[k-1];
          a_q[k]   <= a_q[k-1];
        end
      end
      // Flush wins over the advance, including the op being accepted this edge.
      if (flush) begin
        for (int k = 1; k < LAT; k++) v_q[k] <= 1'b0;
      end
    end
  end

  logic [P-1:0] p_sum, p_last;
  assign p_sum = ({{(WIDTH-2){pp_hh_q[WIDTH+1]}}, pp_hh_q} << WIDTH)
               + (({{(WIDTH-2){pp_hl_q[WIDTH+1]}}, pp_hl_q}
                 + {{(WIDTH-2){pp_lh_q[WIDTH+1]}}, pp_lh_q}) << H)
               + {{(WIDTH-2){pp_ll_q[WIDTH+1]}}, pp_ll_q};

  generate
    if (LAT == 2) begin : g_no_delay
      assign p_last = p_sum;
    end else begin : g_delay
      logic [P-1:0] p_d [2:LAT-1];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 2; k < LAT; k++) p_d[k] <= '0;
        end else if (clkEn) begin
          p_d[2] <= p_sum;
          for (int k = 3; k < LAT; k++) p_d[k] <= p_d[k-1];
        end
      end
      assign p_last = p_d[LAT-1];
    end
  endgenerate

  logic [WIDTH-1:0] a_last, hi;
  logic             mixed_w, mixed_32;
  assign a_last   = a_q[LAT-1];
  assign hi       = p_last[P-1:WIDTH];
  // Overflow iff the bits above the returned low part are not all copies of its sign bit.
  assign mixed_w  = !((&p_last[P-1:WIDTH-1]) || (~|p_last[P-1:WIDTH-1]));
  assign mixed_32 = !((&p_last[P-1:31]) || (~|p_last[P-1:31]));

`ifdef IMUL_PIPE_BSWAP_EN
  // Full-width swap assumes WIDTH is a whole number of bytes.
  logic [WIDTH-1:0] swap_w;
  always_comb begin
    swap_w = '0;
    for (int i = 0; i < WIDTH / 8; i++) swap_w[8*i +: 8] = a_last[WIDTH-8-8*i +: 8];
  end
`endif

  logic [WIDTH-1:0] res_c;
  logic [5:0]       flg_c;
  logic             cf_c, known, sgn_31, sgn;
  always_comb begin
    res_c  = '0;
    cf_c   = 1'b0;
    known  = 1'b1;
    sgn_31 = 1'b0;
    case (op_q[LAT-1])
      4'd0: begin res_c = p_last[WIDTH-1:0]; cf_c = mixed_w; end
      4'd1: begin res_c = hi; cf_c = |hi; end
      4'd2, 4'd3: begin res_c = hi; cf_c = mixed_w; end
      4'd4: begin
        res_c  = WIDTH'(p_last[31:0]);
        cf_c   = |p_last[63:32];
        sgn_31 = 1'b1;
      end
      4'd5: begin
        res_c  = WIDTH'($signed(p_last[31:0]));
        cf_c   = mixed_32;
        sgn_31 = 1'b1;
      end
      4'd8: res_c = a_last;
`ifdef IMUL_PIPE_BSWAP_EN
      4'd6: res_c = WIDTH'({a_last[7:0], a_last[15:8], a_last[23:16], a_last[31:24]});
      4'd7: res_c = swap_w;
`endif
      default: known = 1'b0;
    endcase
    sgn   = sgn_31 ? res_c[31] : res_c[WIDTH-1];
    flg_c = known ? {cf_c, cf_c, 1'b0, sgn, ~|res_c, ~^res_c[7:0]} : 6'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      Res       <= '0;
      flg       <= '0;
      tag_out   <= '0;
    end else begin
      if (clkEn) begin
        valid_out <= v_q[LAT-1];
        Res       <= res_c;
        flg       <= flg_c;
        tag_out   <= tag_q[LAT-1];
      end
      if (flush) valid_out <= 1'b0;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 1; k < LAT; k++) busy = busy | v_q[k];
  end

endmodule
